mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Arbitrates one shared single-port unified SRAM between the IF stage (instruction fetch)
//  and the MEM stage (loads/stores). Sequences multi-cycle SRAM accesses with a fixed
//  wait-state count and raises stall_req_o to the pipeline control until the stalled
//  requester's access completes. Sits between if/mem stages and the external SRAM pins.
// PARAMETERS
//  WAIT_CYCLES  2  SRAM access time in clk cycles, >=1; SRAM signals held this many cycles
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   reset, synchronous, active-high
//  inst_ce_i     in   1   IF fetch request, held stable with address until inst_ready_o
//  inst_addr_i   in   32  fetch address (word aligned)
//  inst_data_o   out  32  fetched word, registered, valid while inst_ready_o=1, held after
//  inst_ready_o  out  1   one-cycle pulse: fetch complete
//  data_ce_i     in   1   MEM-stage access request, held stable until data_ready_o
//  data_we_i     in   1   1=store, 0=load
//  data_sel_i    in   4   byte lane select (bit3 = [31:24])
//  data_addr_i   in   32  data address
//  data_wdata_i  in   32  store data, lanes already replicated by MEM stage
//  data_rdata_o  out  32  load word, registered, updated on load completion only
//  data_ready_o  out  1   one-cycle pulse: load/store complete
//  stall_req_o   out  1   combinational pipeline stall request
//  sram_ce_o     out  1   SRAM chip enable, registered
//  sram_we_o     out  1   SRAM write enable, registered
//  sram_sel_o    out  4   SRAM byte enables, registered
//  sram_addr_o   out  32  SRAM address, registered
//  sram_wdata_o  out  32  SRAM write data, registered
//  sram_rdata_i  in   32  SRAM read data, valid in last wait cycle
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, wait counter 0, last_grant=INST (so data wins first).
//  - FSM IDLE/BUSY. Eligible requester: ce_i=1 and its ready_o=0 this cycle (stale request
//    in its ready cycle is ignored).
//  - IDLE, cycle T: if exactly one eligible -> grant it; if both -> grant the one NOT equal
//    to last_grant; if none -> stay IDLE, SRAM outputs 0. On grant: next state BUSY,
//    counter=0, last_grant<=granted, SRAM outputs loaded from granted request.
//  - Inst grant drives sel=4'b1111, we=0, wdata=0. Data grant passes we/sel/addr/wdata.
//  - BUSY occupies cycles T+1..T+WAIT_CYCLES, SRAM outputs constant, counter increments.
//    At edge ending cycle T+WAIT_CYCLES: capture sram_rdata_i into inst_data_o (inst) or
//    data_rdata_o (data load); pulse granted ready_o for cycle T+WAIT_CYCLES+1; all SRAM
//    outputs <=0; state IDLE. Store completion leaves data_rdata_o unchanged.
//  - Back-to-back same requester: ready period WAIT_CYCLES+2. Other requester can be granted
//    in the ready cycle (zero-bubble switch).
//  - stall_req_o = (data_ce_i & ~data_ready_o) | (inst_ce_i & ~inst_ready_o).
//  - Requester dropping ce mid-BUSY: access still completes (stores not abortable), ready
//    still pulses; no request is queued.
//  - rst during BUSY: access aborted, no ready pulse, SRAM outputs 0 next cycle.
//  - Counter width clog2(WAIT_CYCLES)+1; no wrap in valid operation.
// TESTING
//  1 rst=1 two cycles with both ce=1 -> every output 0, no sram_ce, stall_req_o=1 (comb).
//  2 WAIT=2, inst_ce at T, addr 0x100, sram_rdata=0xDEADBEEF -> sram_ce/addr=0x100 in T+1..T+2,
//    inst_ready pulse at T+3 with inst_data_o=0xDEADBEEF, stall_req_o=1 T..T+2, 0 at T+3.
//  3 Store sel=4'b0100 addr 0x204 wdata 0x00AA0000 -> sram_we=1 sel=0100 exactly 2 cycles,
//    data_ready pulse 1 cycle, data_rdata_o unchanged.
//  4 Both ce=1 at T after reset -> data served first (ready T+3), inst granted at T+3,
//    inst_ready at T+6; data re-requests at T+4, held to T+6 -> data granted at T+6.
//  5 rst asserted at T+1 of a load -> no data_ready ever, sram_ce=0 from T+2, state IDLE.
//  6 WAIT=1, inst_ce held high continuously -> inst_ready pulses every 3 cycles, never
//    two consecutive cycles.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of pipeline-side request/response signals and SRAM pins for mem_bus_arbiter.
// The arbiter takes the slave modport; the pipeline/SRAM environment takes master.
interface mem_bus_arbiter_if;
    // Handshake: a requester raises *_ce_i with its fields and holds them stable until
    // the matching *_ready_o one-cycle pulse; the request seen in that pulse cycle is stale.
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_ready_o;

    logic        data_ce_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;

    logic        stall_req_o;

    logic        sram_ce_o;
    logic        sram_we_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;

    logic [0:0]  dbg_state_o;

    modport slave (
        input  inst_ce_i, inst_addr_i,
        input  data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
        input  sram_rdata_i,
        output inst_data_o, inst_ready_o,
        output data_rdata_o, data_ready_o,
        output stall_req_o,
        output sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o,
        output dbg_state_o
    );

    modport master (
        output inst_ce_i, inst_addr_i,
        output data_ce_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
        output sram_rdata_i,
        input  inst_data_o, inst_ready_o,
        input  data_rdata_o, data_ready_o,
        input  stall_req_o,
        input  sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_wdata_o,
        input  dbg_state_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the MEM stage, holding each
// access for WAIT_CYCLES cycles and alternating grants when both sides contend.
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic G_INST = 1'b0;
    localparam logic G_DATA = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             cur_q, cur_d;

    logic             inst_ready_q, inst_ready_d;
    logic             data_ready_q, data_ready_d;
    logic [31:0]      inst_data_q, inst_data_d;
    logic [31:0]      data_rdata_q, data_rdata_d;

    logic             sram_ce_q, sram_ce_d;
    logic             sram_we_q, sram_we_d;
    logic [3:0]       sram_sel_q, sram_sel_d;
    logic [31:0]      sram_addr_q, sram_addr_d;
    logic [31:0]      sram_wdata_q, sram_wdata_d;

    logic             inst_elig;
    logic             data_elig;
    logic             pick_data;

    // A request still asserted in its own ready cycle has already been served.
    assign inst_elig = bus.inst_ce_i & ~inst_ready_q;
    assign data_elig = bus.data_ce_i & ~data_ready_q;
    assign pick_data = data_elig & (~inst_elig | (last_q == G_INST));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        cur_d        = cur_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        sram_ce_d    = sram_ce_q;
        sram_we_d    = sram_we_q;
        sram_sel_d   = sram_sel_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            S_IDLE: begin
                sram_ce_d    = 1'b0;
                sram_we_d    = 1'b0;
                sram_sel_d   = 4'b0000;
                sram_addr_d  = 32'h0;
                sram_wdata_d = 32'h0;
                if (inst_elig || data_elig) begin
                    state_d   = S_BUSY;
                    cnt_d     = '0;
                    last_d    = pick_data;
                    cur_d     = pick_data;
                    sram_ce_d = 1'b1;
                    if (pick_data) begin
                        sram_we_d    = bus.data_we_i;
                        sram_sel_d   = bus.data_sel_i;
                        sram_addr_d  = bus.data_addr_i;
                        sram_wdata_d = bus.data_wdata_i;
                    end else begin
                        sram_we_d    = 1'b0;
                        sram_sel_d   = 4'b1111;
                        sram_addr_d  = bus.inst_addr_i;
                        sram_wdata_d = 32'h0;
                    end
                end
            end

            S_BUSY: begin
                // Pins stay frozen; the read word is only valid in the final wait cycle.
                if (cnt_q == CNT_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    sram_ce_d    = 1'b0;
                    sram_we_d    = 1'b0;
                    sram_sel_d   = 4'b0000;
                    sram_addr_d  = 32'h0;
                    sram_wdata_d = 32'h0;
                    if (cur_q == G_INST) begin
                        inst_ready_d = 1'b1;
                        inst_data_d  = bus.sram_rdata_i;
                    end else begin
                        data_ready_d = 1'b1;
                        if (!sram_we_q) begin
                            data_rdata_d = bus.sram_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                sram_ce_d    = 1'b0;
                sram_we_d    = 1'b0;
                sram_sel_d   = 4'b0000;
                sram_addr_d  = 32'h0;
                sram_wdata_d = 32'h0;
            end
        endcase
    end

    // Reset aborts any access in flight; last_q starts at INST so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_q       <= G_INST;
            cur_q        <= G_INST;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_data_q  <= 32'h0;
            data_rdata_q <= 32'h0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_sel_q   <= 4'b0000;
            sram_addr_q  <= 32'h0;
            sram_wdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            cur_q        <= cur_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            sram_sel_q   <= sram_sel_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign bus.inst_data_o  = inst_data_q;
    assign bus.inst_ready_o = inst_ready_q;
    assign bus.data_rdata_o = data_rdata_q;
    assign bus.data_ready_o = data_ready_q;
    assign bus.sram_ce_o    = sram_ce_q;
    assign bus.sram_we_o    = sram_we_q;
    assign bus.sram_sel_o   = sram_sel_q;
    assign bus.sram_addr_o  = sram_addr_q;
    assign bus.sram_wdata_o = sram_wdata_q;
    assign bus.dbg_state_o  = state_q;

    // Stall stays combinational so the pipeline freezes in the same cycle it requests.
    assign bus.stall_req_o = (bus.data_ce_i & ~data_ready_q) | (bus.inst_ce_i & ~inst_ready_q);

endmodule
